// File: rtl/proc_datapath.sv
// Execution datapath: register file, A/G operand registers, ALU, shared bus,
// instruction register and the 2-bit timestep counter decoded by the control circuit.
module proc_datapath #(
  parameter int DATA_W = 10,
  parameter int NREG   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic [DATA_W-1:0] DIN,
  input  logic [DATA_W-1:0] IMM,
  input  logic [2:0]        ALUcont,
  input  logic [2:0]        Rin,
  input  logic [2:0]        Rout,
  input  logic              ENW,
  input  logic              ENR,
  input  logic              Ain,
  input  logic              Gin,
  input  logic              Gout,
  input  logic              Ext,
  input  logic              IRin,
  input  logic              done,
  output logic [DATA_W-1:0] INSTR,
  output logic [1:0]        T,
  output logic [DATA_W-1:0] BUS,
  output logic [DATA_W-1:0] DOUT,
  output logic              Z
);

  localparam logic [DATA_W-1:0] ZERO_W = {DATA_W{1'b0}};

  logic [DATA_W-1:0] r_regs [NREG];
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_g;
  logic [DATA_W-1:0] r_ir;
  logic [1:0]        r_t;
  logic              r_z;

  logic [DATA_W-1:0] w_rdata;
  logic [DATA_W-1:0] w_bus;
  logic [DATA_W-1:0] w_alu;

  // Arithmetic wraps at DATA_W bits; codes 110/111 pass the bus through.
  function automatic logic [DATA_W-1:0] alu_fn(
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b,
    input logic [2:0]        op
  );
    case (op)
      3'b000:  alu_fn = a + b;
      3'b001:  alu_fn = a - b;
      3'b010:  alu_fn = ~a;
      3'b011:  alu_fn = a & b;
      3'b100:  alu_fn = a | b;
      3'b101:  alu_fn = a ^ b;
      default: alu_fn = b;
    endcase
  endfunction

  // Register-file read port
  always_comb begin
    w_rdata = ZERO_W;
    if (int'(Rout) < NREG) begin
      w_rdata = r_regs[Rout];
    end else begin
      w_rdata = ZERO_W;
    end
  end

  // Shared bus mux, fixed priority G > register > immediate > DIN
  always_comb begin
    w_bus = DIN;
    if (Gout) begin
      w_bus = r_g;
    end else if (ENR) begin
      w_bus = w_rdata;
    end else if (Ext) begin
      w_bus = IMM;
    end else begin
      w_bus = DIN;
    end
  end

  // ALU result (uses old G when Gout and Gin coincide)
  always_comb begin
    w_alu = alu_fn(r_a, w_bus, ALUcont);
  end

  // Register file write port; reads in the same cycle see the old value
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= ZERO_W;
      end
    end else if (ENW && (int'(Rin) < NREG)) begin
      r_regs[Rin] <= w_bus;
    end
  end

  // A operand register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a <= ZERO_W;
    end else if (Ain) begin
      r_a <= w_bus;
    end
  end

  // G result register and zero flag; Z holds when G is not loaded
  always_ff @(posedge clk) begin
    if (rst) begin
      r_g <= ZERO_W;
      r_z <= 1'b0;
    end else if (Gin) begin
      r_g <= w_alu;
      r_z <= (w_alu == ZERO_W);
    end
  end

  // Instruction register loads straight from DIN, bypassing the bus
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ir <= ZERO_W;
    end else if (IRin) begin
      r_ir <= DIN;
    end
  end

  // Timestep counter; T==3 wraps to 0 so a missing done cannot stall it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_t <= 2'd0;
    end else if (done) begin
      r_t <= 2'd0;
    end else begin
      case (r_t)
        2'd0:    r_t <= run ? 2'd1 : 2'd0;
        2'd1:    r_t <= 2'd2;
        2'd2:    r_t <= 2'd3;
        2'd3:    r_t <= 2'd0;
        default: r_t <= 2'd0;
      endcase
    end
  end

  assign INSTR = r_ir;
  assign T     = r_t;
  assign BUS   = w_bus;
  assign DOUT  = r_g;
  assign Z     = r_z;

endmodule

// File: tb/tb_proc_datapath.sv
// Self-checking bench for proc_datapath: directed scenarios plus randomized
// traffic compared against a behavioural model of the datapath.
module tb_proc_datapath;

  localparam int W    = 10;
  localparam int MASK = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst, run, ENW, ENR, Ain, Gin, Gout, Ext, IRin, done;
  logic [W-1:0] DIN, IMM;
  logic [2:0]   ALUcont, Rin, Rout;
  logic [W-1:0] INSTR, BUS, DOUT;
  logic [1:0]   T;
  logic         Z;

  int m_r [8];
  int m_a, m_g, m_ir, m_t;
  bit m_z;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  proc_datapath #(.DATA_W(W), .NREG(8)) dut (
    .clk(clk), .rst(rst), .run(run), .DIN(DIN), .IMM(IMM), .ALUcont(ALUcont),
    .Rin(Rin), .Rout(Rout), .ENW(ENW), .ENR(ENR), .Ain(Ain), .Gin(Gin),
    .Gout(Gout), .Ext(Ext), .IRin(IRin), .done(done),
    .INSTR(INSTR), .T(T), .BUS(BUS), .DOUT(DOUT), .Z(Z)
  );

  function automatic int model_bus();
    if (Gout)     return m_g;
    else if (ENR) return m_r[Rout];
    else if (Ext) return int'(IMM);
    else          return int'(DIN);
  endfunction

  function automatic int model_alu(int a, int b, int op);
    case (op)
      0:       return (a + b) & MASK;
      1:       return (a - b) & MASK;
      2:       return (~a) & MASK;
      3:       return a & b;
      4:       return a | b;
      5:       return a ^ b;
      default: return b;
    endcase
  endfunction

  // Advance the model by one edge from the current inputs, then clock the DUT.
  task automatic tick();
    int b, res;
    b   = model_bus();
    res = model_alu(m_a, b, int'(ALUcont));
    if (rst) begin
      for (int i = 0; i < 8; i++) m_r[i] = 0;
      m_a = 0; m_g = 0; m_ir = 0; m_t = 0; m_z = 1'b0;
    end else begin
      if (ENW)  m_r[Rin] = b;
      if (Ain)  m_a = b;
      if (Gin) begin m_g = res; m_z = (res == 0); end
      if (IRin) m_ir = int'(DIN);
      if (done)           m_t = 0;
      else if (m_t == 0)  m_t = run ? 1 : 0;
      else                m_t = (m_t + 1) % 4;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; run = 1'b0; ENW = 1'b0; ENR = 1'b0; Ain = 1'b0; Gin = 1'b0;
    Gout = 1'b0; Ext = 1'b0; IRin = 1'b0; done = 1'b0;
    ALUcont = 3'd0; Rin = 3'd0; Rout = 3'd0;
    DIN = W'($urandom); IMM = W'($urandom);
  endtask

  task automatic write_reg(input int idx, input int val);
    idle(); DIN = W'(val); ENW = 1'b1; Rin = 3'(idx);
    tick();
    idle();
  endtask

  task automatic test_reset();
    idle(); rst = 1'b1; tick(); idle();
    for (int i = 0; i < 8; i++) write_reg(i, i * 37 + 5);
    DIN = 10'h2A5; Ain = 1'b1; IRin = 1'b1; run = 1'b1; tick();
    idle(); DIN = 10'h011; Gin = 1'b1; ALUcont = 3'd0; tick();
    idle(); rst = 1'b1; tick(); idle();
    checks++; if (T !== 2'd0)      begin errors++; $display("FAIL reset_T got %0d want 0", T); end
    checks++; if (INSTR !== 10'd0) begin errors++; $display("FAIL reset_INSTR got %h want 000", INSTR); end
    checks++; if (DOUT !== 10'd0)  begin errors++; $display("FAIL reset_DOUT got %h want 000", DOUT); end
    checks++; if (Z !== 1'b0)      begin errors++; $display("FAIL reset_Z got %b want 0", Z); end
    for (int i = 0; i < 8; i++) begin
      ENR = 1'b1; Rout = 3'(i); #1;
      checks++; if (BUS !== 10'd0) begin errors++; $display("FAIL reset_R%0d got %h want 000", i, BUS); end
    end
    idle();
  endtask

  task automatic test_load();
    idle(); DIN = 10'h155; ENW = 1'b1; Rin = 3'd3; IRin = 1'b1; tick();
    idle(); ENR = 1'b1; Rout = 3'd3; #1;
    checks++; if (BUS !== 10'h155)   begin errors++; $display("FAIL load_R3 got %h want 155", BUS); end
    checks++; if (INSTR !== 10'h155) begin errors++; $display("FAIL load_INSTR got %h want 155", INSTR); end
    idle();
  endtask

  task automatic test_add_wrap();
    write_reg(1, 'h3FF);
    write_reg(2, 'h002);
    ENR = 1'b1; Rout = 3'd1; Ain = 1'b1; tick();
    idle(); ENR = 1'b1; Rout = 3'd2; Gin = 1'b1; ALUcont = 3'b000; tick();
    idle();
    checks++; if (DOUT !== 10'h001) begin errors++; $display("FAIL add_wrap_DOUT got %h want 001", DOUT); end
    checks++; if (Z !== 1'b0)       begin errors++; $display("FAIL add_wrap_Z got %b want 0", Z); end
  endtask

  task automatic test_sub_zero();
    write_reg(5, 'h123);
    DIN = 10'h0AA; Ain = 1'b1; tick();
    idle(); DIN = 10'h0AA; Gin = 1'b1; ALUcont = 3'b001; tick();
    idle();
    checks++; if (DOUT !== 10'h000) begin errors++; $display("FAIL sub_zero_DOUT got %h want 000", DOUT); end
    checks++; if (Z !== 1'b1)       begin errors++; $display("FAIL sub_zero_Z got %b want 1", Z); end
    Gout = 1'b1; ENW = 1'b1; Rin = 3'd5; tick();
    idle(); ENR = 1'b1; Rout = 3'd5; #1;
    checks++; if (BUS !== 10'h000) begin errors++; $display("FAIL sub_zero_R5 got %h want 000", BUS); end
    checks++; if (Z !== 1'b1)      begin errors++; $display("FAIL z_hold got %b want 1", Z); end
    idle();
  endtask

  task automatic test_step_counter();
    int seq [4] = '{1, 2, 3, 0};
    idle();
    checks++; if (T !== 2'd0) begin errors++; $display("FAIL step_start got %0d want 0", T); end
    run = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(); run = 1'b0;
      checks++; if (int'(T) !== seq[i]) begin errors++; $display("FAIL step_seq%0d got %0d want %0d", i, T, seq[i]); end
    end
    tick();
    checks++; if (T !== 2'd0) begin errors++; $display("FAIL step_hold got %0d want 0", T); end
    run = 1'b1; tick(); run = 1'b0; tick();
    done = 1'b1; tick(); done = 1'b0;
    checks++; if (T !== 2'd0) begin errors++; $display("FAIL step_done got %0d want 0", T); end
    run = 1'b1; tick(); run = 1'b0; tick();
    checks++; if (T !== 2'd2) begin errors++; $display("FAIL step_at2 got %0d want 2", T); end
    run = 1'b1; tick();
    checks++; if (T !== 2'd3) begin errors++; $display("FAIL step_run_ignored got %0d want 3", T); end
    tick(); run = 1'b0;
    checks++; if (T !== 2'd0) begin errors++; $display("FAIL step_wrap_run got %0d want 0", T); end
    tick();
    checks++; if (T !== 2'd0) begin errors++; $display("FAIL step_idle got %0d want 0", T); end
    idle();
  endtask

  task automatic test_priority_reset();
    write_reg(4, 'h0F0);
    DIN = 10'h2C3; Ain = 1'b1; tick();
    idle(); DIN = 10'h2C3; Gin = 1'b1; ALUcont = 3'b110; tick();
    idle(); IMM = 10'h05A; DIN = 10'h3C0;
    Gout = 1'b1; ENR = 1'b1; Rout = 3'd4; Ext = 1'b1; #1;
    checks++; if (BUS !== 10'h2C3) begin errors++; $display("FAIL prio_G got %h want 2c3", BUS); end
    Gout = 1'b0; #1;
    checks++; if (BUS !== 10'h0F0) begin errors++; $display("FAIL prio_R got %h want 0f0", BUS); end
    ENR = 1'b0; #1;
    checks++; if (BUS !== 10'h05A) begin errors++; $display("FAIL prio_IMM got %h want 05a", BUS); end
    Ext = 1'b0; #1;
    checks++; if (BUS !== 10'h3C0) begin errors++; $display("FAIL prio_DIN got %h want 3c0", BUS); end
    idle(); run = 1'b1; tick(); run = 1'b0; tick();
    rst = 1'b1; ENW = 1'b1; Rin = 3'd6; DIN = 10'h3AB; Gin = 1'b1; tick();
    idle();
    checks++; if (T !== 2'd0)     begin errors++; $display("FAIL midop_T got %0d want 0", T); end
    checks++; if (DOUT !== 10'd0) begin errors++; $display("FAIL midop_DOUT got %h want 000", DOUT); end
    ENR = 1'b1; Rout = 3'd6; #1;
    checks++; if (BUS !== 10'd0)  begin errors++; $display("FAIL midop_R6 got %h want 000", BUS); end
    idle();
  endtask

  task automatic test_random();
    int exp_bus;
    for (int n = 0; n < 400; n++) begin
      rst  = ($urandom_range(0, 59) == 0);
      run  = 1'($urandom); ENW = 1'($urandom); ENR = 1'($urandom);
      Ain  = 1'($urandom); Gin = 1'($urandom); Gout = ($urandom_range(0, 3) == 0);
      Ext  = 1'($urandom); IRin = 1'($urandom); done = ($urandom_range(0, 5) == 0);
      ALUcont = 3'($urandom); Rin = 3'($urandom); Rout = 3'($urandom);
      DIN  = ($urandom_range(0, 7) == 0) ? W'(m_a) : W'($urandom);
      IMM  = W'($urandom);
      #1;
      exp_bus = model_bus();
      checks++; if (int'(BUS) !== exp_bus) begin errors++; $display("FAIL rnd_BUS cyc %0d got %h want %h", n, BUS, exp_bus); end
      tick();
      checks++; if (int'(INSTR) !== m_ir) begin errors++; $display("FAIL rnd_INSTR cyc %0d got %h want %h", n, INSTR, m_ir); end
      checks++; if (int'(T) !== m_t)      begin errors++; $display("FAIL rnd_T cyc %0d got %0d want %0d", n, T, m_t); end
      checks++; if (int'(DOUT) !== m_g)   begin errors++; $display("FAIL rnd_DOUT cyc %0d got %h want %h", n, DOUT, m_g); end
      checks++; if (Z !== m_z)            begin errors++; $display("FAIL rnd_Z cyc %0d got %b want %b", n, Z, m_z); end
    end
    idle();
  endtask

  initial begin
    idle();
    #2;
    test_reset();
    test_load();
    test_add_wrap();
    test_sub_zero();
    test_step_counter();
    test_priority_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
